// File: rtl/reverb_predelay_line.sv
// ---------------------------------------------------------------------------
// reverb_predelay_line
//
// Streaming pre-delay stage for the left audio channel. It delays each sample
// by a software-programmed number of samples, using a circular buffer held in
// inferred block RAM. Each sample makes one pass through a three-state
// handshake FSM:
//   IDLE : accept a sample, write it to the buffer, issue the delayed read
//   RD   : pick the output (bypass, masked zero, or RAM data) and register it
//   HOLD : present the output until the downstream stage takes it
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high reset
//   snk_data       input sample (two's complement, passed through untouched)
//   snk_valid      input sample valid
//   snk_ready      block can accept a sample (registered)
//   src_data       delayed output sample (registered)
//   src_valid      output sample valid (registered)
//   src_ready      downstream accepts the sample
//   predelay_value requested delay in samples (quasi-static PIO value)
//   delay_clamped  the most recently latched delay was saturated to DEPTH-1
// ---------------------------------------------------------------------------
module reverb_predelay_line #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_valid,
    output logic              snk_ready,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    input  logic [23:0]       predelay_value,
    output logic              delay_clamped
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned PD_W  = 24;

    // Largest usable delay, in both the PIO width and the pointer width
    localparam logic [PD_W-1:0]   MAX_DELAY_PD = PD_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] MAX_DELAY    = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Registered state
    state_t              state_q,     state_d;
    logic [DATA_W-1:0]   x_q,         x_d;
    logic [ADDR_W-1:0]   dly_q,       dly_d;
    logic [ADDR_W-1:0]   wp_q,        wp_d;
    logic [ADDR_W-1:0]   fill_q,      fill_d;
    logic [DATA_W-1:0]   src_data_q,  src_data_d;
    logic                src_valid_q, src_valid_d;
    logic                snk_ready_q, snk_ready_d;
    logic                clamp_q,     clamp_d;

    // Combinational helpers
    logic                accept_c;
    logic                over_c;
    logic [ADDR_W-1:0]   dly_sat_c;
    logic [ADDR_W-1:0]   rd_addr_c;
    logic [DATA_W-1:0]   y_c;

    // Circular buffer; contents are never cleared, the fill count masks them
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_data_q;

    // A sample is taken only on a real handshake in IDLE
    assign accept_c = (state_q == ST_IDLE) && snk_ready_q && snk_valid;

    // Saturate the requested delay to what the buffer can hold
    assign over_c    = (predelay_value > MAX_DELAY_PD);
    assign dly_sat_c = over_c ? MAX_DELAY : predelay_value[ADDR_W-1:0];

    // Read slot trails the write slot by the delay; wraps modulo DEPTH
    assign rd_addr_c = wp_q - dly_sat_c;

    // Output select for the sample in flight
    always_comb begin
        y_c = rd_data_q;
        if (dly_q == '0) begin
            // Zero delay bypasses the RAM, which also sidesteps the
            // read-during-write on the slot just written
            y_c = x_q;
        end else if (fill_q < dly_q) begin
            // The requested history has not been written since reset
            y_c = '0;
        end
    end

    // Buffer write and synchronous read, both issued on acceptance
    always_ff @(posedge clk) begin
        if (accept_c) begin
            mem[wp_q] <= snk_data;
            rd_data_q <= mem[rd_addr_c];
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        dly_d       = dly_q;
        wp_d        = wp_q;
        fill_d      = fill_q;
        src_data_d  = src_data_q;
        src_valid_d = src_valid_q;
        clamp_d     = clamp_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    x_d     = snk_data;
                    dly_d   = dly_sat_c;
                    clamp_d = over_c;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                src_data_d  = y_c;
                src_valid_d = 1'b1;
                wp_d        = wp_q + ADDR_W'(1);
                fill_d      = (fill_q == MAX_DELAY) ? fill_q : fill_q + ADDR_W'(1);
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (src_ready) begin
                    src_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Ready is a registered copy of "will be in IDLE next cycle"
        snk_ready_d = (state_d == ST_IDLE);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            dly_q       <= '0;
            wp_q        <= '0;
            fill_q      <= '0;
            src_data_q  <= '0;
            src_valid_q <= 1'b0;
            snk_ready_q <= 1'b0;
            clamp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            dly_q       <= dly_d;
            wp_q        <= wp_d;
            fill_q      <= fill_d;
            src_data_q  <= src_data_d;
            src_valid_q <= src_valid_d;
            snk_ready_q <= snk_ready_d;
            clamp_q     <= clamp_d;
        end
    end

    assign snk_ready     = snk_ready_q;
    assign src_data      = src_data_q;
    assign src_valid     = src_valid_q;
    assign delay_clamped = clamp_q;

endmodule

// File: tb/tb_reverb_predelay_line.sv
// ---------------------------------------------------------------------------
// tb_reverb_predelay_line
//
// Self-checking bench for reverb_predelay_line, built with a 16-entry buffer
// so that clamping and pointer wrap are reached quickly. A behavioural model
// (sample history since reset) computes each expected output when a sample is
// accepted; a negedge monitor pops and compares whenever an output transfers,
// and also checks that a stalled output holds still.
// ---------------------------------------------------------------------------
module tb_reverb_predelay_line;

    localparam int unsigned DATA_W     = 24;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned MAX_D      = (1 << ADDR_W) - 1;
    localparam int unsigned WAIT_LIMIT = 100;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] snk_data;
    logic              snk_valid;
    logic              snk_ready;
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic [23:0]       predelay_value;
    logic              delay_clamped;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] hist  [$];

    logic              hold_pend;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] rec_data;

    reverb_predelay_line #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .snk_data      (snk_data),
        .snk_valid     (snk_valid),
        .snk_ready     (snk_ready),
        .src_data      (src_data),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .predelay_value(predelay_value),
        .delay_clamped (delay_clamped)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp_v);
        end
    endtask

    // Present one sample; the model computes its expected output on acceptance
    task automatic send(input logic [DATA_W-1:0] x, input logic [23:0] pd);
        int n;
        int d;
        int fill;
        logic [DATA_W-1:0] e;
        n = 0;
        @(posedge clk); #1;
        snk_data       = x;
        snk_valid      = 1'b1;
        predelay_value = pd;
        while (!snk_ready && n < WAIT_LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        if (!snk_ready) begin
            check_val("send_ready_timeout", 32'(snk_ready), 32'd1);
            snk_valid = 1'b0;
            return;
        end
        d    = (pd > MAX_D) ? int'(MAX_D) : int'(pd);
        fill = (hist.size() > int'(MAX_D)) ? int'(MAX_D) : hist.size();
        if (d == 0)
            e = x;
        else if (fill < d)
            e = '0;
        else
            e = hist[hist.size() - d];
        hist.push_back(x);
        exp_q.push_back(e);
        @(posedge clk); #1;
        snk_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!src_valid && n < WAIT_LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        if (!src_valid)
            check_val(tag, 32'(src_valid), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        hist.delete();
        exp_q.delete();
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // Output monitor: scoreboard compare on transfer, stability while stalled
    initial begin
        logic [DATA_W-1:0] exp_v;
        hold_pend = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    check_val("hold_valid", 32'(src_valid), 32'd1);
                    check_val("hold_data", 32'(src_data), 32'(hold_data));
                end
                hold_pend = 1'b0;
                if (src_valid && src_ready) begin
                    check_val("out_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        exp_v = exp_q.pop_front();
                        check_val("out_data", 32'(src_data), 32'(exp_v));
                    end
                end else if (src_valid) begin
                    hold_pend = 1'b1;
                    hold_data = src_data;
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        snk_valid      = 1'b0;
        snk_data       = '0;
        src_ready      = 1'b1;
        predelay_value = '0;

        // Power-on reset with traffic on the sink
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            snk_valid = ((i % 2) == 1);
            snk_data  = 24'(i * 17 + 3);
            check_val("rst_snk_ready", 32'(snk_ready), 32'd0);
            check_val("rst_src_valid", 32'(src_valid), 32'd0);
        end
        check_val("rst_src_data", 32'(src_data), 32'd0);
        check_val("rst_clamped", 32'(delay_clamped), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        snk_valid = 1'b0;
        check_val("rel_snk_ready_low", 32'(snk_ready), 32'd0);
        @(posedge clk); #1;
        check_val("rel_snk_ready_high", 32'(snk_ready), 32'd1);

        // Zero delay bypass and latency from the presenting edge
        send(24'h123456, 24'd0);
        check_val("lat_not_yet", 32'(src_valid), 32'd0);
        @(posedge clk); #1;
        check_val("lat_valid", 32'(src_valid), 32'd1);
        check_val("lat_data", 32'(src_data), 32'h123456);
        repeat (3) @(posedge clk);

        // Delay of three from an empty history
        do_reset();
        for (int i = 1; i <= 5; i++)
            send(24'(i), 24'd3);
        repeat (4) @(posedge clk);

        // Oversized delay clamps to DEPTH-1
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(24'h000100 + 24'(i), 24'hFFFFFF);
            if (i == 0)
                check_val("clamp_set", 32'(delay_clamped), 32'd1);
        end
        send(24'h000555, 24'd2);
        check_val("clamp_clear", 32'(delay_clamped), 32'd0);
        repeat (4) @(posedge clk);

        // Ramp across two pointer wraps
        do_reset();
        for (int i = 0; i < 40; i++)
            send(24'hA00000 + 24'(i), 24'd5);
        repeat (4) @(posedge clk);

        // Backpressure in HOLD
        src_ready = 1'b0;
        send(24'hBEEF01, 24'd2);
        wait_valid("bp_valid_timeout");
        rec_data = src_data;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_val("bp_valid", 32'(src_valid), 32'd1);
            check_val("bp_data", 32'(src_data), 32'(rec_data));
            check_val("bp_snk_ready", 32'(snk_ready), 32'd0);
        end
        src_ready = 1'b1;
        @(posedge clk); #1;
        check_val("bp_release_valid", 32'(src_valid), 32'd0);
        check_val("bp_release_ready", 32'(snk_ready), 32'd1);
        send(24'hBEEF02, 24'd2);
        repeat (4) @(posedge clk);

        // Reset while a clamped sample sits stalled in HOLD
        src_ready = 1'b0;
        send(24'h0C0FFE, 24'hFFFFFF);
        wait_valid("mid_valid_timeout");
        check_val("mid_clamp_before", 32'(delay_clamped), 32'd1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check_val("mid_src_valid", 32'(src_valid), 32'd0);
        check_val("mid_src_data", 32'(src_data), 32'd0);
        check_val("mid_clamped", 32'(delay_clamped), 32'd0);
        check_val("mid_snk_ready", 32'(snk_ready), 32'd0);
        hist.delete();
        exp_q.delete();
        src_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            snk_valid = ((i % 2) == 0);
            snk_data  = 24'h3C0000 + 24'(i);
        end
        @(negedge clk);
        reset     = 1'b0;
        snk_valid = 1'b0;
        check_val("mid_rel_low", 32'(snk_ready), 32'd0);
        @(posedge clk); #1;
        check_val("mid_rel_high", 32'(snk_ready), 32'd1);
        send(24'h777777, 24'd2);
        send(24'h888888, 24'd0);
        send(24'h999999, 24'd1);
        repeat (5) @(posedge clk);

        check_val("drain_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
